// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
// Instruction-fetch bus between the control unit and instruction memory /
// instruction register.
//   imem_req : fetch request          (control unit -> memory)
//   imem_ack : fetch data valid        (memory -> control unit)
//   opcode   : instruction-register opcode field (IR -> control unit)
//   ir_load  : load the instruction register     (control unit -> IR)
// master modport: control unit side. slave modport: memory / IR side.
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4
);
  logic                imem_req;
  logic                imem_ack;
  logic                ir_load;
  logic [OPCODE_W-1:0] opcode;

  modport master (
    output imem_req,
    output ir_load,
    input  imem_ack,
    input  opcode
  );

  modport slave (
    input  imem_req,
    input  ir_load,
    output imem_ack,
    output opcode
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Sequences each instruction through FETCH, DECODE, EXEC and WB. MUL holds
// EXEC for MUL_LAT cycles; HALT (and, when trapping, undefined opcodes)
// parks the unit in HALTED until rst.
//
// Optional feature macro: CU_ILLEGAL_TRAP_EN
//   defined   : undefined opcode sets illegal and halt, enters HALTED
//   undefined : undefined opcode executes as NOP and is retired
//
// Ports:
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   start       : leave IDLE and begin fetching
//   imem        : fetch bus (imem_req, imem_ack, opcode, ir_load)
//   ALUControl  : ALU operation, latched in DECODE
//   ALUSrc      : immediate operand select, latched in DECODE
//   RegWrite    : register-file write enable (WB only)
//   pc_en       : advance PC (WB only)
//   busy        : not IDLE and not HALTED
//   halt        : sticky halt
//   illegal     : sticky undefined-opcode flag
//   retired     : retired-instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALUCTL_W = 3,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  multicycle_control_unit_if.master imem,
  output logic [ALUCTL_W-1:0]       ALUControl,
  output logic                      ALUSrc,
  output logic                      RegWrite,
  output logic                      pc_en,
  output logic                      busy,
  output logic                      halt,
  output logic                      illegal,
  output logic [CNT_W-1:0]          retired
);

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_t;

  state_t              state_reg, state_next;
  logic [ALUCTL_W-1:0] ctl_reg;
  logic                src_reg;
  logic                wr_reg;
  logic [LAT_W-1:0]    lat_reg;
  logic                halt_reg;
  logic                illegal_reg;
  logic [CNT_W-1:0]    retired_reg;

  // Any opcode bit above bit 3 makes the instruction undefined.
  logic upper_set;
  generate
    if (OPCODE_W > 4) begin : g_hi
      assign upper_set = |imem.opcode[OPCODE_W-1:4];
    end else begin : g_no_hi
      assign upper_set = 1'b0;
    end
  endgenerate

  // Opcode decode; NOP, HALT and undefined opcodes all decode to zero controls.
  logic [2:0] dec_ctl;
  logic       dec_src, dec_wr, dec_mul, dec_halt, dec_undef;

  always_comb begin
    dec_ctl   = 3'b000;
    dec_src   = 1'b0;
    dec_wr    = 1'b0;
    dec_mul   = 1'b0;
    dec_halt  = 1'b0;
    dec_undef = 1'b0;
    if (upper_set) begin
      dec_undef = 1'b1;
    end else begin
      case (imem.opcode[3:0])
        4'b0000: ;
        4'b0001: dec_wr = 1'b1;
        4'b0010: begin dec_ctl = 3'b001; dec_wr = 1'b1; end
        4'b0011: begin dec_ctl = 3'b100; dec_wr = 1'b1; dec_mul = 1'b1; end
        4'b0101: begin dec_src = 1'b1; dec_wr = 1'b1; end
        4'b1111: dec_halt = 1'b1;
        default: dec_undef = 1'b1;
      endcase
    end
  end

  logic trap_now;
  assign trap_now = dec_halt || (dec_undef && TRAP_EN);

  always_comb begin
    state_next    = state_reg;
    imem.imem_req = 1'b0;
    imem.ir_load  = 1'b0;
    RegWrite      = 1'b0;
    pc_en         = 1'b0;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          imem.ir_load = 1'b1;
          state_next   = S_DECODE;
        end
      end
      S_DECODE: state_next = trap_now ? S_HALTED : S_EXEC;
      S_EXEC:   if (lat_reg == '0) state_next = S_WB;
      S_WB: begin
        RegWrite   = wr_reg;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      ctl_reg     <= '0;
      src_reg     <= 1'b0;
      wr_reg      <= 1'b0;
      lat_reg     <= '0;
      halt_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_DECODE: begin
          ctl_reg <= ALUCTL_W'(dec_ctl);
          src_reg <= dec_src;
          wr_reg  <= dec_wr;
          // EXEC leaves when this counter reads zero, so MUL sees MUL_LAT cycles.
          lat_reg <= dec_mul ? LAT_W'(MUL_LAT - 1) : '0;
          if (trap_now) halt_reg <= 1'b1;
          if (dec_undef && TRAP_EN) illegal_reg <= 1'b1;
        end
        S_EXEC:  if (lat_reg != '0) lat_reg <= lat_reg - LAT_W'(1);
        S_WB:    retired_reg <= retired_reg + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign ALUControl = ctl_reg;
  assign ALUSrc     = src_reg;
  assign busy       = (state_reg != S_IDLE) && (state_reg != S_HALTED);
  assign halt       = halt_reg;
  assign illegal    = illegal_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// Bench for multicycle_control_unit (OPCODE_W=5, ALUCTL_W=4, MUL_LAT=3).
// A second instance with CNT_W=2 shares all stimulus to exercise wrapping.
// The reference model keeps a schedule of pending instruction phases and
// predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;
  localparam int OW  = 5;
  localparam int CW  = 4;
  localparam int LAT = 3;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk, rst, start, ack_v;
  logic [OW-1:0] op_v;

  multicycle_control_unit_if #(.OPCODE_W(OW)) bus ();
  multicycle_control_unit_if #(.OPCODE_W(OW)) bus_w ();
  assign bus.imem_ack   = ack_v;
  assign bus.opcode     = op_v;
  assign bus_w.imem_ack = ack_v;
  assign bus_w.opcode   = op_v;

  logic [CW-1:0] ctl, ctl_w;
  logic src, rw, pc, busy, hlt, ill;
  logic src_w, rw_w, pc_w, busy_w, hlt_w, ill_w;
  logic [15:0] ret;
  logic [1:0]  ret_w;

  multicycle_control_unit #(.OPCODE_W(OW), .ALUCTL_W(CW), .MUL_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .imem(bus),
    .ALUControl(ctl), .ALUSrc(src), .RegWrite(rw), .pc_en(pc),
    .busy(busy), .halt(hlt), .illegal(ill), .retired(ret));

  multicycle_control_unit #(.OPCODE_W(OW), .ALUCTL_W(CW), .MUL_LAT(LAT), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .start(start), .imem(bus_w),
    .ALUControl(ctl_w), .ALUSrc(src_w), .RegWrite(rw_w), .pc_en(pc_w),
    .busy(busy_w), .halt(hlt_w), .illegal(ill_w), .retired(ret_w));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] ctl;
    logic       src;
    logic       wr;
    logic [3:0] nexec;
    logic       is_halt;
    logic       is_undef;
  } dec_t;

  function automatic dec_t model_dec(input logic [OW-1:0] op);
    dec_t d;
    d = '0;
    d.nexec = 4'd1;
    if (op > 15) d.is_undef = 1'b1;
    else begin
      case (int'(op))
        0:  ;
        1:  d.wr = 1'b1;
        2:  begin d.ctl = 3'd1; d.wr = 1'b1; end
        3:  begin d.ctl = 3'd4; d.wr = 1'b1; d.nexec = 4'(LAT); end
        5:  begin d.src = 1'b1; d.wr = 1'b1; end
        15: d.is_halt = 1'b1;
        default: d.is_undef = 1'b1;
      endcase
    end
    return d;
  endfunction

  // mode: 0 idle, 1 running, 2 halted. Phase queue: 1 decode, 2 exec, 3 write-back.
  int m_mode = 0;
  int m_q[$];
  logic [CW-1:0] m_ctl = '0;
  logic m_src = 0, m_wr = 0, m_halt = 0, m_ill = 0;
  int unsigned m_ret = 0;

  logic [11:0] obs_vec, obs_vec_w;
  logic [15:0] obs_ret;
  logic [1:0]  obs_ret_w;

  function automatic logic [11:0] pack_out(input logic r, i, w, p, b, h, il, s, input logic [CW-1:0] c);
    return {r, i, w, p, b, h, il, s, c};
  endfunction

  task automatic model_edge();
    int k;
    dec_t d;
    if (rst) begin
      m_mode = 0; m_q.delete(); m_ctl = '0; m_src = 0; m_wr = 0;
      m_halt = 0; m_ill = 0; m_ret = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_q.size() == 0) begin
        if (ack_v) m_q.push_back(1);
      end else begin
        k = m_q.pop_front();
        if (k == 1) begin
          d = model_dec(op_v);
          m_ctl = CW'(d.ctl); m_src = d.src; m_wr = d.wr;
          if (d.is_halt || (d.is_undef && TRAP)) begin
            m_halt = 1'b1;
            if (d.is_undef) m_ill = 1'b1;
            m_mode = 2;
          end else begin
            for (int e = 0; e < int'(d.nexec); e++) m_q.push_back(2);
            m_q.push_back(3);
          end
        end else if (k == 3) begin
          m_ret++;
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic e_req, e_ir, e_rw, e_pc;
    int k;
    logic [11:0] e_vec;
    @(negedge clk);
    k     = (m_q.size() != 0) ? m_q[0] : 0;
    e_req = (m_mode == 1) && (m_q.size() == 0);
    e_ir  = e_req && ack_v;
    e_rw  = (k == 3) && m_wr;
    e_pc  = (k == 3);
    e_vec = pack_out(e_req, e_ir, e_rw, e_pc, m_mode == 1, m_halt, m_ill, m_src, m_ctl);
    obs_vec   = pack_out(bus.imem_req, bus.ir_load, rw, pc, busy, hlt, ill, src, ctl);
    obs_vec_w = pack_out(bus_w.imem_req, bus_w.ir_load, rw_w, pc_w, busy_w, hlt_w, ill_w, src_w, ctl_w);
    obs_ret   = ret;
    obs_ret_w = ret_w;
    chk("outputs", 32'(obs_vec), 32'(e_vec));
    chk("outputs_w", 32'(obs_vec_w), 32'(e_vec));
    chk("retired", 32'(obs_ret), m_ret % 65536);
    chk("retired_w", 32'(obs_ret_w), m_ret % 4);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ack_v = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Fetch one instruction: waitc cycles without ack, then the ack cycle.
  // Returns the number of cycles after the ack cycle until pc_en and the WB outputs.
  task automatic run_instr(input logic [OW-1:0] op, input int waitc,
                           output int lat, output logic [11:0] wbvec);
    bit found;
    ack_v = 1'b0;
    for (int i = 0; i < waitc; i++) begin
      cycle();
      chk("req_held", 32'(obs_vec[11]), 32'd1);
    end
    ack_v = 1'b1; op_v = op;
    cycle();
    chk("ack_ir_load", 32'(obs_vec[10]), 32'd1);
    ack_v = 1'b0;
    found = 1'b0; lat = -1; wbvec = '0;
    for (int i = 1; i <= 20 && !found; i++) begin
      cycle();
      if (obs_vec[8]) begin found = 1'b1; lat = i; wbvec = obs_vec; end
    end
    chk("wb_reached", 32'(found), 32'd1);
  endtask

  typedef struct {
    logic [OW-1:0] op;
    int            waitc;
    int            exp_lat;
    logic [CW-1:0] exp_ctl;
    logic          exp_src;
    logic          exp_rw;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int lat;
    logic [11:0] wb;
    logic [11:0] held;
    logic [OW-1:0] pick[16];

    tbl[0] = '{op: 5'd1, waitc: 0, exp_lat: 3, exp_ctl: 4'd0, exp_src: 1'b0, exp_rw: 1'b1};
    tbl[1] = '{op: 5'd5, waitc: 5, exp_lat: 3, exp_ctl: 4'd0, exp_src: 1'b1, exp_rw: 1'b1};
    tbl[2] = '{op: 5'd2, waitc: 5, exp_lat: 3, exp_ctl: 4'd1, exp_src: 1'b0, exp_rw: 1'b1};
    tbl[3] = '{op: 5'd3, waitc: 0, exp_lat: 5, exp_ctl: 4'd4, exp_src: 1'b0, exp_rw: 1'b1};
    tbl[4] = '{op: 5'd0, waitc: 2, exp_lat: 3, exp_ctl: 4'd0, exp_src: 1'b0, exp_rw: 1'b0};
    tbl[5] = '{op: 5'd3, waitc: 1, exp_lat: 5, exp_ctl: 4'd4, exp_src: 1'b0, exp_rw: 1'b1};
    tbl[6] = '{op: 5'd5, waitc: 0, exp_lat: 3, exp_ctl: 4'd0, exp_src: 1'b1, exp_rw: 1'b1};

    rst = 1'b1; start = 1'b0; ack_v = 1'b0; op_v = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cycle();
    chk("reset_outputs", 32'(obs_vec), 32'd0);
    chk("reset_retired", 32'(obs_ret), 32'd0);

    // Table-driven instructions
    do_reset();
    for (int t = 0; t < 7; t++) begin
      run_instr(tbl[t].op, tbl[t].waitc, lat, wb);
      chk($sformatf("tbl%0d_latency", t), 32'(lat), 32'(tbl[t].exp_lat));
      chk($sformatf("tbl%0d_ctl", t), 32'(wb[3:0]), 32'(tbl[t].exp_ctl));
      chk($sformatf("tbl%0d_src", t), 32'(wb[4]), 32'(tbl[t].exp_src));
      chk($sformatf("tbl%0d_regwrite", t), 32'(wb[9]), 32'(tbl[t].exp_rw));
      $display("tbl %0d op=%0d lat=%0d ctl=%0d src=%0d rw=%0d", t, tbl[t].op, lat, wb[3:0], wb[4], wb[9]);
    end
    cycle();
    chk("tbl_retired", 32'(obs_ret), 32'd7);
    chk("req_after_wb", 32'(obs_vec[11]), 32'd1);

    // HALT after two ADDs, then start/ack are ignored
    do_reset();
    run_instr(5'd1, 0, lat, wb);
    run_instr(5'd1, 0, lat, wb);
    ack_v = 1'b1; op_v = 5'd15;
    cycle();
    ack_v = 1'b0;
    cycle();
    cycle();
    chk("halt_flag", 32'(obs_vec[6]), 32'd1);
    chk("halt_busy", 32'(obs_vec[7]), 32'd0);
    chk("halt_retired", 32'(obs_ret), 32'd2);
    held = obs_vec;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; ack_v = i[0];
      cycle();
    end
    start = 1'b0; ack_v = 1'b0;
    chk("halt_sticky", 32'(obs_vec), 32'(held));
    chk("halt_sticky_ret", 32'(obs_ret), 32'd2);
    $display("halt seq: halt=%0d busy=%0d retired=%0d", obs_vec[6], obs_vec[7], obs_ret);

    // Undefined opcode 0111
    do_reset();
    if (TRAP) begin
      ack_v = 1'b1; op_v = 5'd7;
      cycle();
      ack_v = 1'b0;
      cycle();
      cycle();
      chk("illegal_flag", 32'(obs_vec[5]), 32'd1);
      chk("illegal_halt", 32'(obs_vec[6]), 32'd1);
      chk("illegal_retired", 32'(obs_ret), 32'd0);
    end else begin
      run_instr(5'd7, 0, lat, wb);
      chk("undef_latency", 32'(lat), 32'd3);
      chk("undef_regwrite", 32'(wb[9]), 32'd0);
      chk("undef_illegal", 32'(wb[5]), 32'd0);
      cycle();
      chk("undef_retired", 32'(obs_ret), 32'd1);
    end
    $display("undef seq: illegal=%0d halt=%0d retired=%0d", obs_vec[5], obs_vec[6], obs_ret);

    // Reset during the second MUL EXEC cycle
    do_reset();
    ack_v = 1'b1; op_v = 5'd3;
    cycle();             // ack
    ack_v = 1'b0;
    cycle();             // decode
    cycle();             // exec 1
    rst = 1'b1;
    cycle();             // exec 2, reset sampled at its end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rst_mid_mul_idle", 32'(obs_vec), 32'd0);
    end
    $display("mul reset seq: outputs=0x%0h retired=%0d", obs_vec, obs_ret);

    // Five NOPs: the CNT_W=2 instance wraps to 1
    do_reset();
    for (int i = 0; i < 5; i++) run_instr(5'd0, 0, lat, wb);
    cycle();
    chk("wrap_retired_w", 32'(obs_ret_w), 32'd1);
    chk("wrap_retired", 32'(obs_ret), 32'd5);
    $display("wrap seq: retired=%0d retired_w=%0d", obs_ret, obs_ret_w);

    // Randomised traffic against the model
    pick = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd0, 5'd1, 5'd2, 5'd3,
             5'd5, 5'd0, 5'd7, 5'd4, 5'd17, 5'd30, 5'd15, 5'd1};
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(199) == 0) || (obs_vec[6] && $urandom_range(3) == 0);
      start = ($urandom_range(7) == 0);
      ack_v = ($urandom_range(2) == 0);
      op_v  = pick[$urandom_range(15)];
      cycle();
    end
    rst = 1'b0; start = 1'b0; ack_v = 1'b0;
    $display("random phase done: retired=%0d", obs_ret);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
